ahb_lite_master: RTL and testbench

AHB-Lite initiator that turns a simple command/stream interface into pipelined AHB-Lite read or write transfers. It is the master-side counterpart to the SRAM, UART and seg7 slaves on the interconnect. It lets a non-CPU agent (DMA, UART loader, test sequencer) drive the same bus matrix.
One command moves 1 to 2^LEN_W beats of byte, halfword or word data at incrementing addresses.

---
 rtl/ahb_lite_master.sv | 210 +++++++++++++++++++++
 tb/tb_ahb_lite_master.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns a command/stream interface into pipelined
// single (NONSEQ) AHB-Lite transfers at incrementing addresses.
module ahb_lite_master #(
   parameter int unsigned LEN_W     = 8,
   parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
   input  logic             clk,
   input  logic             RSTn,
   // command side
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic [31:0]      cmd_addr,
   input  logic [2:0]       cmd_size,
   input  logic [LEN_W-1:0] cmd_len,
   // write stream
   input  logic [31:0]      wr_data,
   output logic             wr_ack,
   // read stream / status
   output logic [31:0]      rd_data,
   output logic             rd_valid,
   output logic             done,
   output logic             err,
   // AHB-Lite master
   output logic [31:0]      HADDR,
   output logic [1:0]       HTRANS,
   output logic [2:0]       HSIZE,
   output logic [2:0]       HBURST,
   output logic [3:0]       HPROT,
   output logic             HMASTLOCK,
   output logic             HWRITE,
   output logic [31:0]      HWDATA,
   input  logic [31:0]      HRDATA,
   input  logic             HREADY,
   input  logic             HRESP
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_PIPE = 3'd2;
   localparam logic [2:0] S_DATA = 3'd3;
   localparam logic [2:0] S_ERR1 = 3'd4;

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;

   logic [2:0]       state_q,    state_d;
   logic [LEN_W-1:0] cnt_q,      cnt_d;
   logic [1:0]       htrans_q,   htrans_d;
   logic [31:0]      haddr_q,    haddr_d;
   logic             hwrite_q,   hwrite_d;
   logic [2:0]       hsize_q,    hsize_d;
   logic [31:0]      hwdata_q,   hwdata_d;
   logic [31:0]      rd_data_q,  rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic             done_q,     done_d;
   logic             err_q,      err_d;

   logic [2:0]       size_clamp;
   logic [31:0]      addr_aligned;
   logic [31:0]      addr_inc;
   logic             addr_done;

   // Size clamp and start-address alignment for an incoming command
   always_comb begin
      size_clamp   = (cmd_size > 3'd2) ? 3'd2 : cmd_size;
      addr_aligned = cmd_addr;
      case (size_clamp)
         3'd0:    addr_aligned = cmd_addr;
         3'd1:    addr_aligned = {cmd_addr[31:1], 1'b0};
         default: addr_aligned = {cmd_addr[31:2], 2'b00};
      endcase
   end

   assign addr_inc = 32'd1 << hsize_q;

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      htrans_d   = htrans_q;
      haddr_d    = haddr_q;
      hwrite_d   = hwrite_q;
      hsize_d    = hsize_q;
      hwdata_d   = hwdata_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      wr_ack     = 1'b0;
      addr_done  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               state_d  = S_ADDR;
               htrans_d = TR_NONSEQ;
               haddr_d  = addr_aligned;
               hwrite_d = cmd_write;
               hsize_d  = size_clamp;
               cnt_d    = cmd_len;
            end
         end
         S_ADDR: addr_done = HREADY;
         S_PIPE: begin
            if (HREADY) begin
               if (HRESP) begin
                  // late error seen already completing: abort at once
                  state_d  = S_IDLE;
                  htrans_d = TR_IDLE;
                  done_d   = 1'b1;
                  err_d    = 1'b1;
               end else begin
                  addr_done = 1'b1;
                  if (!hwrite_q) begin
                     rd_data_d  = HRDATA;
                     rd_valid_d = 1'b1;
                  end
               end
            end else if (HRESP) begin
               state_d  = S_ERR1;
               htrans_d = TR_IDLE;
            end
         end
         S_DATA: begin
            if (HREADY) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               err_d   = HRESP;
               if (!HRESP && !hwrite_q) begin
                  rd_data_d  = HRDATA;
                  rd_valid_d = 1'b1;
               end
            end else if (HRESP) begin
               state_d = S_ERR1;
            end
         end
         S_ERR1: begin
            htrans_d = TR_IDLE;
            if (HREADY) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end
         end
         default: begin
            state_d  = S_IDLE;
            htrans_d = TR_IDLE;
         end
      endcase

      // address phase completion: issue next address or enter final data phase
      if (addr_done) begin
         wr_ack = hwrite_q;
         if (hwrite_q) hwdata_d = wr_data;
         if (cnt_q == '0) begin
            state_d  = S_DATA;
            htrans_d = TR_IDLE;
         end else begin
            state_d = S_PIPE;
            cnt_d   = cnt_q - LEN_W'(1);
            haddr_d = haddr_q + addr_inc;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         htrans_q   <= TR_IDLE;
         haddr_q    <= '0;
         hwrite_q   <= 1'b0;
         hsize_q    <= 3'b010;
         hwdata_q   <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         htrans_q   <= htrans_d;
         haddr_q    <= haddr_d;
         hwrite_q   <= hwrite_d;
         hsize_q    <= hsize_d;
         hwdata_q   <= hwdata_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign HADDR     = haddr_q;
   assign HTRANS    = htrans_q;
   assign HSIZE     = hsize_q;
   assign HWRITE    = hwrite_q;
   assign HWDATA    = hwdata_q;
   assign HBURST    = 3'b000;
   assign HPROT     = HPROT_VAL;
   assign HMASTLOCK = 1'b0;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Scoreboard bench for ahb_lite_master with a reactive AHB-Lite slave model.
module tb_ahb_lite_master;

   logic        clk, RSTn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [2:0]  cmd_size;
   logic [7:0]  cmd_len;
   logic [31:0] wr_data, rd_data, HADDR, HWDATA, HRDATA;
   logic        wr_ack, rd_valid, done, err, HMASTLOCK, HWRITE, HREADY, HRESP;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;

   ahb_lite_master #(.LEN_W(8), .HPROT_VAL(4'b0011)) dut (
      .clk(clk), .RSTn(RSTn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_ack(wr_ack), .rd_data(rd_data), .rd_valid(rd_valid),
      .done(done), .err(err), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
      .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWRITE(HWRITE),
      .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP));

   typedef struct { logic [31:0] addr; logic wr; logic [2:0] sz; } aexp_t;
   typedef struct { int waits; bit err; logic [31:0] rdata; } slv_t;

   aexp_t       addr_exp[$];
   logic [31:0] wd_exp[$], rd_exp[$], wr_src[$];
   logic        done_exp[$];
   slv_t        slv_q[$];

   int n_chk = 0, n_fail = 0, cyc = 0, ack_total = 0;
   bit sb_en = 1, adv = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic fail_msg(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: got event/timeout, required none", nm);
   endtask

   // Slave: decides HREADY/HRESP/HRDATA at each negedge for the current cycle
   initial begin : slave
      slv_t cur;
      bit   in_data, err_stage, ready_prev, nonseq_prev;
      in_data = 0; err_stage = 0; ready_prev = 1; nonseq_prev = 0;
      cur = '{0, 1'b0, 32'h0};
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hBAD0_BAD0;
      forever begin
         @(negedge clk);
         HRDATA = 32'hBAD0_BAD0;
         if (!RSTn) begin
            in_data = 0; err_stage = 0; ready_prev = 1; nonseq_prev = 0;
            HREADY = 1'b1; HRESP = 1'b0;
         end else begin
            if (ready_prev && nonseq_prev) begin
               if (slv_q.size() == 0) begin
                  fail_msg("slave_unexpected_data_phase");
                  in_data = 0;
               end else begin
                  cur = slv_q.pop_front();
                  in_data = 1; err_stage = 0;
               end
            end
            if (in_data) begin
               if (cur.waits > 0) begin
                  HREADY = 1'b0; HRESP = 1'b0; cur.waits--;
               end else if (cur.err) begin
                  if (!err_stage) begin
                     HREADY = 1'b0; HRESP = 1'b1; err_stage = 1;
                  end else begin
                     chk("err2_htrans_idle", 32'(HTRANS), 32'h0);
                     HREADY = 1'b1; HRESP = 1'b1; in_data = 0;
                  end
               end else begin
                  HREADY = 1'b1; HRESP = 1'b0; HRDATA = cur.rdata; in_data = 0;
               end
            end else begin
               HREADY = 1'b1; HRESP = 1'b0;
            end
            ready_prev  = HREADY;
            nonseq_prev = (HTRANS == 2'b10);
         end
      end
   end

   // Write source: after a consumed beat, present the next one after the edge
   initial begin : wsrc
      forever begin
         @(posedge clk); #1;
         if (adv) begin
            adv = 0;
            if (wr_src.size() > 0) void'(wr_src.pop_front());
            wr_data = (wr_src.size() > 0) ? wr_src[0] : 32'h0;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents an event
   initial begin : monitor
      aexp_t       ea;
      logic [31:0] hwd_val, prev_addr, prev_wd;
      bit          hwd_pend, prev_wait;
      hwd_pend = 0; prev_wait = 0; hwd_val = 0; prev_addr = 0; prev_wd = 0;
      forever begin
         @(negedge clk); #1;
         if (!RSTn) begin
            hwd_pend = 0; prev_wait = 0;
         end else begin
            if (wr_ack) begin ack_total++; adv = 1; end
            if (sb_en) begin
               if (prev_wait) begin
                  chk("wait_haddr_stable", HADDR, prev_addr);
                  chk("wait_hwdata_stable", HWDATA, prev_wd);
               end
               if (hwd_pend) begin chk("hwdata", HWDATA, hwd_val); hwd_pend = 0; end
               if (HTRANS == 2'b10 && HREADY) begin
                  if (addr_exp.size() == 0) fail_msg("unexpected_addr_phase");
                  else begin
                     ea = addr_exp.pop_front();
                     chk("haddr", HADDR, ea.addr);
                     chk("hwrite", 32'(HWRITE), 32'(ea.wr));
                     chk("hsize", 32'(HSIZE), 32'(ea.sz));
                  end
               end
               if (wr_ack) begin
                  if (wd_exp.size() == 0) fail_msg("unexpected_wr_ack");
                  else begin hwd_val = wd_exp.pop_front(); hwd_pend = 1; end
               end
               if (rd_valid) begin
                  if (rd_exp.size() == 0) fail_msg("unexpected_rd_valid");
                  else chk("rd_data", rd_data, rd_exp.pop_front());
               end
               if (done) begin
                  if (done_exp.size() == 0) fail_msg("unexpected_done");
                  else chk("done_err", 32'(err), 32'(done_exp.pop_front()));
               end
            end
            prev_wait = (HTRANS == 2'b10) && !HREADY && !HRESP;
            prev_addr = HADDR;
            prev_wd   = HWDATA;
         end
      end
   end

   task automatic chk_reset(input string p);
      chk({p, "_htrans"}, 32'(HTRANS), 32'h0);
      chk({p, "_haddr"}, HADDR, 32'h0);
      chk({p, "_hwrite"}, 32'(HWRITE), 32'h0);
      chk({p, "_hsize"}, 32'(HSIZE), 32'h2);
      chk({p, "_hwdata"}, HWDATA, 32'h0);
      chk({p, "_rd_data"}, rd_data, 32'h0);
      chk({p, "_rd_valid"}, 32'(rd_valid), 32'h0);
      chk({p, "_done"}, 32'(done), 32'h0);
      chk({p, "_err"}, 32'(err), 32'h0);
      chk({p, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
   endtask

   task automatic issue(input bit w, input logic [31:0] a, input logic [2:0] s,
                        input logic [7:0] l, output int acc, output bit done_at_acc);
      int  k;
      bit  ok;
      ok = 0; acc = 0; done_at_acc = 0;
      for (k = 0; k < 200 && !ok; k++) begin
         @(negedge clk); #1;
         if (cmd_ready) ok = 1;
      end
      if (!ok) fail_msg("cmd_ready_timeout");
      else begin
         cmd_write = w; cmd_addr = a; cmd_size = s; cmd_len = l; cmd_valid = 1'b1;
         acc = cyc; done_at_acc = done;
         @(negedge clk);
         cmd_valid = 1'b0;
      end
   endtask

   task automatic wait_done(output int dc);
      bit found;
      found = 0; dc = -1;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge clk); #2;
         if (done === 1'b1) begin found = 1; dc = cyc; end
      end
      if (!found) fail_msg("done_timeout");
   endtask

   task automatic push_src(input logic [31:0] d);
      wr_src.push_back(d);
      wr_data = wr_src[0];
   endtask

   initial begin : stim
      int acc, acc2, dc, base;
      bit d0, d1;
      RSTn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 0;
      cmd_size = 0; cmd_len = 0; wr_data = 0;
      repeat (2) @(negedge clk);
      #2 chk_reset("reset");
      chk("hburst", 32'(HBURST), 32'h0);
      chk("hprot", 32'(HPROT), 32'h3);
      chk("hmastlock", 32'(HMASTLOCK), 32'h0);
      @(negedge clk); RSTn = 1'b1;

      // single-beat word write
      addr_exp.push_back('{32'h2000_0004, 1'b1, 3'd2});
      wd_exp.push_back(32'hDEAD_BEEF); push_src(32'hDEAD_BEEF);
      slv_q.push_back('{0, 1'b0, 32'h0}); done_exp.push_back(1'b0);
      issue(1'b1, 32'h2000_0004, 3'd2, 8'd0, acc, d0);
      wait_done(dc); chk("t1_latency", 32'(dc - acc), 32'd3);

      // 4-beat read, 2 wait states on beat 1
      slv_q.push_back('{0, 1'b0, 32'h11}); slv_q.push_back('{2, 1'b0, 32'h22});
      slv_q.push_back('{0, 1'b0, 32'h33}); slv_q.push_back('{0, 1'b0, 32'h44});
      for (int i = 0; i < 4; i++) addr_exp.push_back('{32'h10 + 32'(4 * i), 1'b0, 3'd2});
      rd_exp.push_back(32'h11); rd_exp.push_back(32'h22);
      rd_exp.push_back(32'h33); rd_exp.push_back(32'h44);
      done_exp.push_back(1'b0);
      issue(1'b0, 32'h10, 3'd2, 8'd3, acc, d0);
      wait_done(dc); chk("t2_latency", 32'(dc - acc), 32'd8);

      // byte write from unaligned address
      for (int i = 0; i < 4; i++) begin
         addr_exp.push_back('{32'h4000_0003 + 32'(i), 1'b1, 3'd0});
         wd_exp.push_back(32'hA0 + 32'(i)); push_src(32'hA0 + 32'(i));
         slv_q.push_back('{0, 1'b0, 32'h0});
      end
      done_exp.push_back(1'b0);
      issue(1'b1, 32'h4000_0003, 3'd0, 8'd3, acc, d0);
      wait_done(dc); chk("t3_latency", 32'(dc - acc), 32'd6);

      // halfword alignment clears bit0
      addr_exp.push_back('{32'h4000_0002, 1'b1, 3'd1});
      wd_exp.push_back(32'h1234_0000); push_src(32'h1234_0000);
      slv_q.push_back('{0, 1'b0, 32'h0}); done_exp.push_back(1'b0);
      issue(1'b1, 32'h4000_0003, 3'd1, 8'd0, acc, d0);
      wait_done(dc);

      // size 7 behaves as word
      addr_exp.push_back('{32'h4000_0004, 1'b1, 3'd2});
      addr_exp.push_back('{32'h4000_0008, 1'b1, 3'd2});
      wd_exp.push_back(32'h0000_0B01); push_src(32'h0000_0B01);
      wd_exp.push_back(32'h0000_0B02); push_src(32'h0000_0B02);
      slv_q.push_back('{0, 1'b0, 32'h0}); slv_q.push_back('{0, 1'b0, 32'h0});
      done_exp.push_back(1'b0);
      issue(1'b1, 32'h4000_0007, 3'd7, 8'd1, acc, d0);
      wait_done(dc); chk("t3c_latency", 32'(dc - acc), 32'd4);

      // read with ERROR on beat 1
      slv_q.push_back('{0, 1'b0, 32'h55}); slv_q.push_back('{0, 1'b1, 32'h0});
      addr_exp.push_back('{32'h100, 1'b0, 3'd2}); addr_exp.push_back('{32'h104, 1'b0, 3'd2});
      rd_exp.push_back(32'h55); done_exp.push_back(1'b1);
      issue(1'b0, 32'h100, 3'd2, 8'd3, acc, d0);
      wait_done(dc);
      chk("t4_latency", 32'(dc - acc), 32'd5);
      chk("t4_err", 32'(err), 32'h1);
      chk("t4_cmd_ready", 32'(cmd_ready), 32'h1);

      // back-to-back reads with address wrap
      slv_q.push_back('{0, 1'b0, 32'h66}); slv_q.push_back('{0, 1'b0, 32'h77});
      slv_q.push_back('{0, 1'b0, 32'h88});
      addr_exp.push_back('{32'hFFFF_FFFC, 1'b0, 3'd2});
      addr_exp.push_back('{32'hFFFF_FFFC, 1'b0, 3'd2});
      addr_exp.push_back('{32'h0000_0000, 1'b0, 3'd2});
      rd_exp.push_back(32'h66); rd_exp.push_back(32'h77); rd_exp.push_back(32'h88);
      done_exp.push_back(1'b0); done_exp.push_back(1'b0);
      issue(1'b0, 32'hFFFF_FFFC, 3'd2, 8'd0, acc, d0);
      issue(1'b0, 32'hFFFF_FFFC, 3'd2, 8'd1, acc2, d1);
      chk("t5_accept_in_done", 32'(d1), 32'h1);
      chk("t5_accept_gap", 32'(acc2 - acc), 32'd3);
      wait_done(dc); chk("t5_latency", 32'(dc - acc2), 32'd4);

      // reset in the middle of an 8-beat write
      sb_en = 0;
      for (int i = 0; i < 8; i++) begin
         slv_q.push_back('{0, 1'b0, 32'h0}); push_src(32'h700 + 32'(i));
      end
      base = ack_total;
      issue(1'b1, 32'h300, 3'd2, 8'd7, acc, d0);
      for (int k = 0; k < 50 && ack_total < base + 3; k++) @(negedge clk);
      chk("t6_acks_before_reset", 32'(ack_total >= base + 3), 32'h1);
      @(negedge clk);
      RSTn = 1'b0;
      #2 chk_reset("t6_rst");
      addr_exp.delete(); wd_exp.delete(); rd_exp.delete(); done_exp.delete();
      slv_q.delete(); wr_src.delete(); wr_data = 0; adv = 0; sb_en = 1;
      repeat (2) @(negedge clk);
      RSTn = 1'b1;
      repeat (3) @(negedge clk);

      // fresh command after reset release
      addr_exp.push_back('{32'h500, 1'b1, 3'd2});
      wd_exp.push_back(32'hCAFE_F00D); push_src(32'hCAFE_F00D);
      slv_q.push_back('{0, 1'b0, 32'h0}); done_exp.push_back(1'b0);
      issue(1'b1, 32'h500, 3'd2, 8'd0, acc, d0);
      wait_done(dc); chk("t7_latency", 32'(dc - acc), 32'd3);

      repeat (4) @(negedge clk);
      chk("addr_q_drained", 32'(addr_exp.size()), 32'h0);
      chk("wd_q_drained", 32'(wd_exp.size()), 32'h0);
      chk("rd_q_drained", 32'(rd_exp.size()), 32'h0);
      chk("done_q_drained", 32'(done_exp.size()), 32'h0);
      chk("slv_q_drained", 32'(slv_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
